// File: rtl/regfile_arb.sv
//------------------------------------------------------------------------------
// regfile_arb : two-client arbiter sharing the 4x8 regfile read/write ports.
// Macro REGFILE_ARB_RR_EN selects round-robin; default is fixed priority.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regfile_arb #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic       clk,
  input  logic       sync_rst,
  input  logic       req_valid_0,
  input  logic       req_valid_1,
  output logic       req_ready_0,
  output logic       req_ready_1,
  input  logic       req_write_0,
  input  logic       req_write_1,
  input  logic [1:0] req_addr_a_0,
  input  logic [1:0] req_addr_a_1,
  input  logic [1:0] req_addr_b_0,
  input  logic [1:0] req_addr_b_1,
  input  logic [7:0] req_data_0,
  input  logic [7:0] req_data_1,
  output logic       rsp_valid_0,
  output logic       rsp_valid_1,
  output logic [7:0] rsp_data_a,
  output logic [7:0] rsp_data_b,
  output logic       rf_read_en_A,
  output logic       rf_read_en_B,
  output logic       rf_write_en,
  output logic [1:0] rf_addr_read_A,
  output logic [1:0] rf_addr_read_B,
  output logic [1:0] rf_addr_write,
  output logic [7:0] rf_data_in,
  input  logic [7:0] rf_data_out_A,
  input  logic [7:0] rf_data_out_B
);

  logic       grant_0;
  logic       grant_1;
  logic       win;
  logic       sel_write;
  logic [1:0] sel_addr_a;
  logic [1:0] sel_addr_b;
  logic [7:0] sel_data;
  logic       rsp_pending_q, rsp_pending_d;
  logic       rsp_owner_q, rsp_owner_d;

`ifdef REGFILE_ARB_RR_EN
  logic last_grant_q, last_grant_d;

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!sync_rst) begin
      if (req_valid_0 && req_valid_1) begin
        grant_0 = last_grant_q;
        grant_1 = !last_grant_q;
      end else begin
        grant_0 = req_valid_0;
        grant_1 = req_valid_1;
      end
    end
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (grant_1)      last_grant_d = 1'b1;
    else if (grant_0) last_grant_d = 1'b0;
  end

  // Reset value 1 means "client 1 won last", so client 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (sync_rst) last_grant_q <= 1'b1;
    else          last_grant_q <= last_grant_d;
  end
`else
  localparam logic [3:0] STARVE_LIMIT_W = 4'(STARVE_LIMIT);

  logic [3:0] starve_cnt_q, starve_cnt_d;

  always_comb begin
    grant_0 = 1'b0;
    grant_1 = 1'b0;
    if (!sync_rst) begin
      grant_1 = req_valid_1 && (!req_valid_0 || (starve_cnt_q == STARVE_LIMIT_W));
      grant_0 = req_valid_0 && !grant_1;
    end
  end

  // Counter cannot pass the limit: reaching it forces a grant, which clears it.
  always_comb begin
    starve_cnt_d = 4'd0;
    if (req_valid_1 && !grant_1) starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) starve_cnt_q <= 4'd0;
    else          starve_cnt_q <= starve_cnt_d;
  end
`endif

  assign req_ready_0 = grant_0;
  assign req_ready_1 = grant_1;

  always_comb begin
    win        = grant_0 || grant_1;
    sel_write  = grant_1 ? req_write_1  : req_write_0;
    sel_addr_a = grant_1 ? req_addr_a_1 : req_addr_a_0;
    sel_addr_b = grant_1 ? req_addr_b_1 : req_addr_b_0;
    sel_data   = grant_1 ? req_data_1   : req_data_0;
  end

  always_comb begin
    rf_read_en_A   = 1'b0;
    rf_read_en_B   = 1'b0;
    rf_write_en    = 1'b0;
    rf_addr_read_A = 2'd0;
    rf_addr_read_B = 2'd0;
    rf_addr_write  = 2'd0;
    rf_data_in     = 8'd0;
    if (win && !sel_write) begin
      rf_read_en_A   = 1'b1;
      rf_read_en_B   = 1'b1;
      rf_addr_read_A = sel_addr_a;
      rf_addr_read_B = sel_addr_b;
    end else if (win && sel_write) begin
      rf_write_en   = 1'b1;
      rf_addr_write = sel_addr_a;
      rf_data_in    = sel_data;
    end
  end

  always_comb begin
    rsp_pending_d = win && !sel_write;
    rsp_owner_d   = rsp_owner_q;
    if (win && !sel_write) rsp_owner_d = grant_1;
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      rsp_pending_q <= 1'b0;
      rsp_owner_q   <= 1'b0;
    end else begin
      rsp_pending_q <= rsp_pending_d;
      rsp_owner_q   <= rsp_owner_d;
    end
  end

  // Masking with reset drops a response whose read was accepted just before reset.
  assign rsp_valid_0 = rsp_pending_q && !rsp_owner_q && !sync_rst;
  assign rsp_valid_1 = rsp_pending_q &&  rsp_owner_q && !sync_rst;
  assign rsp_data_a  = rf_data_out_A;
  assign rsp_data_b  = rf_data_out_B;

endmodule

`default_nettype wire

// File: tb/tb_regfile_arb.sv
//------------------------------------------------------------------------------
// tb_regfile_arb : directed self-checking bench with a behavioural 4x8 regfile.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regfile_arb;

  logic       clk = 1'b0;
  logic       sync_rst;
  logic       req_valid_0, req_valid_1;
  logic       req_ready_0, req_ready_1;
  logic       req_write_0, req_write_1;
  logic [1:0] req_addr_a_0, req_addr_a_1, req_addr_b_0, req_addr_b_1;
  logic [7:0] req_data_0, req_data_1;
  logic       rsp_valid_0, rsp_valid_1;
  logic [7:0] rsp_data_a, rsp_data_b;
  logic       rf_read_en_A, rf_read_en_B, rf_write_en;
  logic [1:0] rf_addr_read_A, rf_addr_read_B, rf_addr_write;
  logic [7:0] rf_data_in;
  logic [7:0] rf_data_out_A, rf_data_out_B;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_arb #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .sync_rst(sync_rst),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .req_write_0(req_write_0), .req_write_1(req_write_1),
    .req_addr_a_0(req_addr_a_0), .req_addr_a_1(req_addr_a_1),
    .req_addr_b_0(req_addr_b_0), .req_addr_b_1(req_addr_b_1),
    .req_data_0(req_data_0), .req_data_1(req_data_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_data_a(rsp_data_a), .rsp_data_b(rsp_data_b),
    .rf_read_en_A(rf_read_en_A), .rf_read_en_B(rf_read_en_B), .rf_write_en(rf_write_en),
    .rf_addr_read_A(rf_addr_read_A), .rf_addr_read_B(rf_addr_read_B),
    .rf_addr_write(rf_addr_write), .rf_data_in(rf_data_in),
    .rf_data_out_A(rf_data_out_A), .rf_data_out_B(rf_data_out_B)
  );

  // Regfile model: registers reset to their own index, read outputs reset to 0.
  logic [7:0] mem [4];
  always @(posedge clk) begin
    if (sync_rst) begin
      for (int i = 0; i < 4; i++) mem[i] <= 8'(i);
      rf_data_out_A <= 8'd0;
      rf_data_out_B <= 8'd0;
    end else begin
      if (rf_write_en)  mem[rf_addr_write] <= rf_data_in;
      if (rf_read_en_A) rf_data_out_A <= mem[rf_addr_read_A];
      if (rf_read_en_B) rf_data_out_B <= mem[rf_addr_read_B];
    end
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_g1;
    sync_rst = 1'b1;
    req_valid_0 = 0; req_valid_1 = 0; req_write_0 = 0; req_write_1 = 0;
    req_addr_a_0 = 0; req_addr_a_1 = 0; req_addr_b_0 = 0; req_addr_b_1 = 0;
    req_data_0 = 0; req_data_1 = 0;
    tick; tick;

    // Requests ignored during reset
    req_valid_0 = 1; req_addr_a_0 = 2'd1;
    #1;
    check("rst_ready_0", req_ready_0, 0);
    check("rst_read_en", rf_read_en_A, 0);
    tick;
    sync_rst = 0; req_valid_0 = 0; req_addr_a_0 = 0;
    #1;
    check("rst_rsp_data_a", rsp_data_a, 8'h00);
    check("rst_rsp_valid_0", rsp_valid_0, 0);
    tick;

    // Client 1 read r1/r2
    req_valid_1 = 1; req_write_1 = 0; req_addr_a_1 = 2'd1; req_addr_b_1 = 2'd2;
    #1;
    check("c1rd_ready_1", req_ready_1, 1);
    check("c1rd_ready_0", req_ready_0, 0);
    check("c1rd_addr_A", rf_addr_read_A, 8'd1);
    check("c1rd_addr_B", rf_addr_read_B, 8'd2);
    tick;
    req_valid_1 = 0;
    #1;
    check("c1rd_rsp_valid_1", rsp_valid_1, 1);
    check("c1rd_rsp_valid_0", rsp_valid_0, 0);
    check("c1rd_data_a", rsp_data_a, 8'd1);
    check("c1rd_data_b", rsp_data_b, 8'd2);
    check("idle_read_en", rf_read_en_A, 0);

    // Client 0 writes 0x5A to r3, then reads r3/r0
    req_valid_0 = 1; req_write_0 = 1; req_addr_a_0 = 2'd3; req_data_0 = 8'h5A;
    #1;
    check("c0wr_ready_0", req_ready_0, 1);
    check("c0wr_write_en", rf_write_en, 1);
    check("c0wr_addr", rf_addr_write, 8'd3);
    check("c0wr_data", rf_data_in, 8'h5A);
    check("c0wr_read_en", rf_read_en_A, 0);
    tick;
    req_write_0 = 0; req_addr_a_0 = 2'd3; req_addr_b_0 = 2'd0; req_data_0 = 0;
    #1;
    check("c0wr_no_rsp", rsp_valid_0, 0);
    check("c0rd_ready_0", req_ready_0, 1);
    tick;
    req_valid_0 = 0;
    #1;
    check("raw_rsp_valid_0", rsp_valid_0, 1);
    check("raw_data_a", rsp_data_a, 8'h5A);
    check("raw_data_b", rsp_data_b, 8'h00);

    // Both clients valid continuously, starting just after reset
    sync_rst = 1;
    tick; tick;
    sync_rst = 0;
    req_valid_0 = 1; req_write_0 = 0; req_addr_a_0 = 2'd0; req_addr_b_0 = 2'd1;
    req_valid_1 = 1; req_write_1 = 0; req_addr_a_1 = 2'd2; req_addr_b_1 = 2'd3;
    #1;
    for (int i = 0; i < 10; i++) begin
`ifdef REGFILE_ARB_RR_EN
      exp_g1 = (i % 2) == 1;
`else
      exp_g1 = (i % 5) == 4;
`endif
      check($sformatf("arb%0d_ready_0", i), req_ready_0, !exp_g1);
      check($sformatf("arb%0d_ready_1", i), req_ready_1, exp_g1);
      tick;
      #1;
      check($sformatf("arb%0d_rsp_valid_1", i), rsp_valid_1, exp_g1);
      check($sformatf("arb%0d_rsp_data_a", i), rsp_data_a, exp_g1 ? 8'd2 : 8'd0);
    end

    // Write from client 0 against a read from client 1: client 0 wins
    req_write_0 = 1; req_addr_a_0 = 2'd0; req_data_0 = 8'h77;
    #1;
    check("wvr_ready_0", req_ready_0, 1);
    check("wvr_ready_1", req_ready_1, 0);
    check("wvr_write_en", rf_write_en, 1);
    check("wvr_read_en", rf_read_en_B, 0);
    tick;
    req_valid_0 = 0; req_valid_1 = 0; req_write_0 = 0; req_data_0 = 0;

    // Read accepted, then reset: response lost
    req_valid_0 = 1; req_addr_a_0 = 2'd1; req_addr_b_0 = 2'd2;
    #1;
    check("rr_ready_0", req_ready_0, 1);
    tick;
    sync_rst = 1;
    #1;
    check("rr_rsp_valid_0", rsp_valid_0, 0);
    check("rr_ready_0_rst", req_ready_0, 0);
    check("rr_read_en_rst", rf_read_en_A, 0);
    tick;
    sync_rst = 0; req_valid_0 = 0;
    #1;
    check("rr_data_a", rsp_data_a, 8'd0);
    check("rr_data_b", rsp_data_b, 8'd0);
    check("rr_rsp_valid_after", rsp_valid_0, 0);

    // Read r3/r1 then stay idle: outputs hold
    req_valid_0 = 1; req_addr_a_0 = 2'd3; req_addr_b_0 = 2'd1;
    tick;
    req_valid_0 = 0; req_addr_a_0 = 0; req_addr_b_0 = 0;
    #1;
    check("idle_first_rsp", rsp_valid_0, 1);
    for (int i = 0; i < 10; i++) begin
      check($sformatf("idle%0d_enables", i), {rf_read_en_A, rf_read_en_B, rf_write_en}, 8'd0);
      check($sformatf("idle%0d_data_in", i), rf_data_in, 8'd0);
      check($sformatf("idle%0d_data_a", i), rsp_data_a, 8'd3);
      check($sformatf("idle%0d_data_b", i), rsp_data_b, 8'd1);
      tick;
      #1;
    end
    check("idle_rsp_valid_0", rsp_valid_0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
